imem_loader_ctrl: RTL and testbench

Program-load controller for the 256-word instruction memory. It accepts a byte stream from a host link such as a UART receiver. It assembles little-endian 32-bit words and drives the memory's write port, writing them from word address 0 upward. It holds the core stalled while loading and releases it once the image is complete. It sits between the host-link receiver, the instruction memory write port and the core's stall/reset input.

---
 rtl/imem_pkg.sv | 7 +
 rtl/byte_word_packer.sv | 24 ++
 rtl/imem_loader_ctrl.sv | 91 +++++++++
 tb/tb_imem_loader_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and state encoding for the instruction-memory loader.
package imem_pkg;
    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;
    localparam int HDR_BYTES  = 2;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE} state_t;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles little-endian bytes into 32-bit words, pulsing word_valid on lane 3.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  lane;
    logic [23:0] acc;
    assign word_valid = en && lane == 2'd3;
    assign word       = {data, acc};
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane <= '0;
            acc  <= '0;
        end else if (en) begin
            lane <= lane + 2'd1;
            if (lane != 2'd3) acc[{lane, 3'b000} +: 8] <= data;
        end
    end
endmodule

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: loads a length-prefixed byte stream into instruction memory while holding the core.
module imem_loader_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          load_busy,
    output logic          load_err,
    output logic [15:0]   words_loaded
);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
    state_t      state, state_n;
    logic [7:0]  n_lo;
    logic [15:0] n_cnt, word_idx, hdr_n;
    logic        xfer, start_ok, word_valid, last_word, keep;
    logic [31:0] word;
    assign in_ready  = state == HDR0 || state == HDR1 || state == DATA;
    assign xfer      = in_valid && in_ready;
    assign start_ok  = state == IDLE && load_start;
    assign hdr_n     = {in_data, n_lo};
    assign last_word = word_valid && word_idx == n_cnt - 16'd1;
    // words past the memory end are still consumed but never written
    assign keep      = word_valid && word_idx < DEPTH16;
    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .en         (xfer && state == DATA),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load_start ? HDR0 : IDLE;
            HDR0:    state_n = in_valid ? HDR1 : HDR0;
            HDR1:    state_n = !in_valid ? HDR1 : (hdr_n == 16'd0 ? DONE : DATA);
            DATA:    state_n = last_word ? DONE : DATA;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            n_lo         <= '0;
            n_cnt        <= '0;
            word_idx     <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b0;
            load_busy    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state     <= state_n;
            cpu_hold  <= state_n != IDLE;
            load_busy <= state_n != IDLE;
            mem_we    <= keep;
            if (keep) begin
                mem_waddr    <= word_idx[AW-1:0];
                mem_wdata    <= word;
                words_loaded <= word_idx + 16'd1;
            end
            if (word_valid) word_idx <= word_idx + 16'd1;
            if (state == HDR0 && xfer) n_lo <= in_data;
            if (state == HDR1 && xfer) begin
                n_cnt    <= hdr_n;
                load_err <= hdr_n > DEPTH16;
            end
            if (start_ok) begin
                load_err     <= 1'b0;
                words_loaded <= '0;
                word_idx     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: directed checks of header parsing, word writes, stalls, overflow and reset.
module tb_imem_loader_ctrl;
    logic        clk = 1'b0, rst = 1'b1, load_start = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, mem_we, cpu_hold, load_busy, load_err;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [15:0] words_loaded;
    int checks = 0, failures = 0, nw = 0, spurious = 0, base = 0;
    logic        prev_x = 1'b0;
    logic [7:0]  wa [0:2047];
    logic [31:0] wd [0:2047];
    logic [7:0]  img [0:9] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h40, 8'h01};

    always #5 clk = ~clk;

    imem_loader_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    // write log; a write is only legal the cycle after a byte transfer
    always @(negedge clk) begin
        if (mem_we) begin
            if (nw < 2048) begin
                wa[nw] = mem_waddr;
                wd[nw] = mem_wdata;
            end
            nw++;
            if (!prev_x) spurious++;
        end
        prev_x = in_valid && in_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(load_busy), 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // basic load
        base = nw;
        start();
        chk("b_busy", 32'(load_busy), 32'd1);
        chk("b_hold", 32'(cpu_hold), 32'd1);
        chk("b_ready", 32'(in_ready), 32'd1);
        send(8'h02);
        send(8'h00);
        send_word(32'h00A00513);
        chk("b_we0", 32'(mem_we), 32'd1);
        chk("b_addr0", 32'(mem_waddr), 32'd0);
        chk("b_data0", mem_wdata, 32'h00A00513);
        chk("b_words1", 32'(words_loaded), 32'd1);
        send_word(32'h01400093);
        chk("b_we1", 32'(mem_we), 32'd1);
        chk("b_addr1", 32'(mem_waddr), 32'd1);
        chk("b_data1", mem_wdata, 32'h01400093);
        chk("b_done_hold", 32'(cpu_hold), 32'd1);
        chk("b_words2", 32'(words_loaded), 32'd2);
        tick();
        chk("b_hold_off", 32'(cpu_hold), 32'd0);
        chk("b_busy_off", 32'(load_busy), 32'd0);
        chk("b_we_off", 32'(mem_we), 32'd0);
        chk("b_nw", 32'(nw - base), 32'd2);
        chk("b_err", 32'(load_err), 32'd0);

        // stalled stream
        base = nw;
        start();
        for (int i = 0; i < 10; i++) begin
            send(img[i]);
            repeat (3) tick();
        end
        chk("s_nw", 32'(nw - base), 32'd2);
        chk("s_addr0", 32'(wa[base]), 32'd0);
        chk("s_data0", wd[base], 32'h00A00513);
        chk("s_addr1", 32'(wa[base+1]), 32'd1);
        chk("s_data1", wd[base+1], 32'h01400093);
        chk("s_spurious", 32'(spurious), 32'd0);
        chk("s_hold", 32'(cpu_hold), 32'd0);
        chk("s_words", 32'(words_loaded), 32'd2);

        // zero count
        base = nw;
        start();
        send(8'h00);
        send(8'h00);
        chk("z_done_busy", 32'(load_busy), 32'd1);
        chk("z_words", 32'(words_loaded), 32'd0);
        tick();
        chk("z_busy", 32'(load_busy), 32'd0);
        chk("z_hold", 32'(cpu_hold), 32'd0);
        chk("z_nw", 32'(nw - base), 32'd0);

        // overflow: 257 words
        base = nw;
        start();
        send(8'h01);
        send(8'h01);
        chk("o_err_hdr", 32'(load_err), 32'd1);
        for (int i = 0; i < 257; i++) send_word(32'hC0DE0000 | 32'(i));
        chk("o_busy_last", 32'(load_busy), 32'd1);
        tick();
        chk("o_nw", 32'(nw - base), 32'd256);
        chk("o_addr100", 32'(wa[base+100]), 32'd100);
        chk("o_data100", wd[base+100], 32'hC0DE0064);
        chk("o_addr255", 32'(wa[base+255]), 32'd255);
        chk("o_data255", wd[base+255], 32'hC0DE00FF);
        chk("o_wdata_kept", mem_wdata, 32'hC0DE00FF);
        chk("o_words", 32'(words_loaded), 32'd256);
        chk("o_err_sticky", 32'(load_err), 32'd1);
        chk("o_busy", 32'(load_busy), 32'd0);
        start();
        chk("o_err_clr", 32'(load_err), 32'd0);
        chk("o_words_clr", 32'(words_loaded), 32'd0);
        send(8'h00);
        send(8'h00);
        tick();

        // reset mid-word
        base = nw;
        start();
        send(8'h02);
        send(8'h00);
        send(8'h13);
        send(8'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("r");
        chk("r_nw", 32'(nw - base), 32'd0);
        tick();
        start();
        for (int i = 0; i < 10; i++) send(img[i]);
        tick();
        chk("r_nw2", 32'(nw - base), 32'd2);
        chk("r_addr0", 32'(wa[base]), 32'd0);
        chk("r_data0", wd[base], 32'h00A00513);
        chk("r_data1", wd[base+1], 32'h01400093);

        // load_start during DATA is ignored
        base = nw;
        start();
        send(8'h02);
        send(8'h00);
        send(8'h13);
        send(8'h05);
        load_start = 1'b1;
        send(8'hA0);
        load_start = 1'b0;
        chk("d_busy", 32'(load_busy), 32'd1);
        chk("d_ready", 32'(in_ready), 32'd1);
        send(8'h00);
        chk("d_we0", 32'(mem_we), 32'd1);
        chk("d_addr0", 32'(mem_waddr), 32'd0);
        chk("d_data0", mem_wdata, 32'h00A00513);
        send_word(32'h01400093);
        chk("d_addr1", 32'(mem_waddr), 32'd1);
        tick();
        chk("d_nw", 32'(nw - base), 32'd2);
        chk("d_data1", wd[base+1], 32'h01400093);
        chk("d_words", 32'(words_loaded), 32'd2);
        chk("d_hold", 32'(cpu_hold), 32'd0);
        chk("d_spurious", 32'(spurious), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
